// File: rtl/phased_array_burst_sequencer_if.sv
// Host-side bundle for the burst sequencer: delay-table config, burst control and speaker drive.
// Latency: none (pure signal bundle).
// Backpressure: none; start/cfg are level-sampled and silently dropped when the sequencer is busy.
interface phased_array_burst_sequencer_if #(
    parameter int NUM_CH  = 37,
    parameter int DELAY_W = 10
);
    logic                cfg_we;
    logic [5:0]          cfg_addr;
    logic [DELAY_W-1:0]  cfg_data;
    logic                start;
    logic                abort;
    logic                busy;
    logic                listening;
    logic                done;
    logic [NUM_CH-1:0]   speakers;

    // Host / config side
    modport master (
        output cfg_we, cfg_addr, cfg_data, start, abort,
        input  busy, listening, done, speakers
    );

    // Sequencer side
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, abort,
        output busy, listening, done, speakers
    );
endinterface

// File: rtl/phased_array_burst_sequencer.sv
// Fires one steered 40 kHz burst on every speaker channel, then holds a listen window and pulses done.
// Latency: channel i rises d_i+1 edges after the edge sampling start; done one cycle after the last LISTEN cycle.
// Backpressure: none; start and config writes are ignored while busy, abort returns to IDLE on the next edge.
module phased_array_burst_sequencer #(
    parameter int NUM_CH        = 37,
    parameter int DELAY_W       = 10,
    parameter int HALF_PERIOD   = 300,
    parameter int BURST_CYCLES  = 8,
    parameter int LISTEN_CYCLES = 24000
) (
    input  logic                          clk24,
    input  logic                          rst_n,
    phased_array_burst_sequencer_if.slave bus
);

    localparam int MAX_DELAY = (1 << DELAY_W) - 1;
    localparam int BURST_LEN = BURST_CYCLES * 2 * HALF_PERIOD;
    // FIRE lasts long enough for the largest possible delay to finish its burst.
    localparam int FIRE_LAST = MAX_DELAY + BURST_LEN - 1;
    localparam int T_W       = $clog2(FIRE_LAST + 1);
    localparam int PH_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int HALVES    = 2 * BURST_CYCLES;
    localparam int HN_W      = $clog2(HALVES + 1);
    localparam int LC_W      = (LISTEN_CYCLES > 1) ? $clog2(LISTEN_CYCLES) : 1;

    localparam logic [T_W-1:0]  T_LAST   = T_W'(FIRE_LAST);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF_PERIOD - 1);
    // Half-period index value meaning "channel not emitting" (before its delay or after its last pulse).
    localparam logic [HN_W-1:0] HN_DONE  = HN_W'(HALVES);
    localparam logic [LC_W-1:0] LC_LAST  = LC_W'(LISTEN_CYCLES - 1);
    localparam logic [5:0]      ADDR_LIM = 6'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRE   = 2'd1,
        S_LISTEN = 2'd2
    } state_t;

    state_t              state;
    logic [T_W-1:0]      t;
    logic [LC_W-1:0]     lc;
    logic                busy_q;
    logic                listening_q;
    logic                done_q;

    logic [DELAY_W-1:0]  dly [NUM_CH];
    logic                cfg_ok;

    // Per-channel carrier position: ph = clocks into the current half period, hn = half-period index.
    logic [PH_W-1:0]     ph_q [NUM_CH];
    logic [HN_W-1:0]     hn_q [NUM_CH];
    logic [PH_W-1:0]     ph_d [NUM_CH];
    logic [HN_W-1:0]     hn_d [NUM_CH];
    logic [NUM_CH-1:0]   spk_d;
    logic [NUM_CH-1:0]   spk_q;

    assign bus.busy      = busy_q;
    assign bus.listening = listening_q;
    assign bus.done      = done_q;
    assign bus.speakers  = spk_q;

    // Table writes only land in IDLE so the delays cannot move under a running burst.
    assign cfg_ok = (state == S_IDLE) && bus.cfg_we && (bus.cfg_addr < ADDR_LIM);

    // Burst control FSM: IDLE -> FIRE (t counts) -> LISTEN (lc counts) -> IDLE with done.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            t           <= '0;
            lc          <= '0;
            busy_q      <= 1'b0;
            listening_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    t  <= '0;
                    lc <= '0;
                    // abort wins over a simultaneous start
                    if (bus.start && !bus.abort) begin
                        state  <= S_FIRE;
                        busy_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        t      <= '0;
                    end else if (t == T_LAST) begin
                        state       <= S_LISTEN;
                        listening_q <= 1'b1;
                        t           <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                S_LISTEN: begin
                    if (bus.abort) begin
                        state       <= S_IDLE;
                        busy_q      <= 1'b0;
                        listening_q <= 1'b0;
                        lc          <= '0;
                    end else if (lc == LC_LAST) begin
                        state       <= S_IDLE;
                        busy_q      <= 1'b0;
                        listening_q <= 1'b0;
                        done_q      <= 1'b1;
                        lc          <= '0;
                    end else begin
                        lc <= lc + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    busy_q      <= 1'b0;
                    listening_q <= 1'b0;
                    t           <= '0;
                    lc          <= '0;
                end
            endcase
        end
    end

    // Steering-delay table; a write in the start cycle is visible at t=0 of that burst.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dly[i] <= '0;
            end
        end else if (cfg_ok) begin
            dly[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Next carrier state per channel: launch when t reaches the channel delay, then walk
    // through HALVES half periods, driving high on the even ones.
    always_comb begin
        logic [PH_W-1:0] cur_ph;
        logic [HN_W-1:0] cur_hn;
        for (int i = 0; i < NUM_CH; i++) begin
            ph_d[i]  = '0;
            hn_d[i]  = HN_DONE;
            spk_d[i] = 1'b0;
            cur_ph   = ph_q[i];
            cur_hn   = hn_q[i];
            if (t == T_W'(dly[i])) begin
                cur_ph = '0;
                cur_hn = '0;
            end
            if ((state == S_FIRE) && !bus.abort && (cur_hn != HN_DONE)) begin
                spk_d[i] = ~cur_hn[0];
                if (cur_ph == PH_LAST) begin
                    ph_d[i] = '0;
                    hn_d[i] = cur_hn + 1'b1;
                end else begin
                    ph_d[i] = cur_ph + 1'b1;
                    hn_d[i] = cur_hn;
                end
            end
        end
    end

    // Register the speaker drive and carrier counters; everything idles outside FIRE.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            spk_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ph_q[i] <= '0;
                hn_q[i] <= HN_DONE;
            end
        end else begin
            spk_q <= spk_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ph_q[i] <= ph_d[i];
                hn_q[i] <= hn_d[i];
            end
        end
    end

endmodule

// File: tb/tb_phased_array_burst_sequencer.sv
// Randomized bench for phased_array_burst_sequencer against a timeline-based reference model.
// Latency: checks every cycle, one time unit after each rising edge.
// Backpressure: none; stimulus is driven open-loop and the model decides what the DUT must accept.
`timescale 1ns/1ps
module tb_phased_array_burst_sequencer;

    localparam int NUM_CH   = 37;
    localparam int DELAY_W  = 10;
    localparam int HP       = 300;
    localparam int BC       = 8;
    localparam int LC       = 24000;
    localparam int MAXD     = (1 << DELAY_W) - 1;
    localparam int BLEN     = BC * 2 * HP;
    localparam int FIRE_LEN = MAXD + BLEN;
    localparam int BUSY_LEN = FIRE_LEN + LC;

    logic clk24 = 1'b0;
    logic rst_n = 1'b0;

    always #20 clk24 = ~clk24;

    phased_array_burst_sequencer_if #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W)) bus();

    phased_array_burst_sequencer #(
        .NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .HALF_PERIOD(HP),
        .BURST_CYCLES(BC), .LISTEN_CYCLES(LC)
    ) dut (
        .clk24(clk24),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Reference model: delay table plus edges elapsed since the edge that accepted start (-1 = idle).
    int m_dly [NUM_CH];
    int m_e;
    bit m_done;

    int n_chk;
    int n_fail;

    // Observed-waveform bookkeeping for the explicit pulse checks.
    int rise_cnt [NUM_CH];
    int first_rise [NUM_CH];
    int n_done;
    int n_busy;
    logic [NUM_CH-1:0] prev_spk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Speaker i is high after edge e when u = e-1-d_i lies in the burst and in a high half period.
    function automatic logic [NUM_CH-1:0] exp_spk();
        logic [NUM_CH-1:0] v;
        v = '0;
        if (m_e >= 1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int u;
                u = m_e - 1 - m_dly[i];
                v[i] = (u >= 0) && (u < BLEN) && ((u % (2 * HP)) < HP);
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_dly[i] = 0;
        m_e    = -1;
        m_done = 1'b0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NUM_CH; i++) begin
            rise_cnt[i]   = 0;
            first_rise[i] = -1;
        end
        n_done = 0;
        n_busy = 0;
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare.
    task automatic tick();
        @(posedge clk24);
        m_done = 1'b0;
        if (rst_n) begin
            if (m_e < 0) begin
                if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_CH))
                    m_dly[bus.cfg_addr] = int'(bus.cfg_data);
                if (bus.start && !bus.abort) m_e = 0;
            end else if (bus.abort) begin
                m_e = -1;
            end else if (m_e == BUSY_LEN - 1) begin
                m_e    = -1;
                m_done = 1'b1;
            end else begin
                m_e++;
            end
        end
        #1;
        chk("speakers", 64'(bus.speakers), 64'(exp_spk()));
        chk("status{busy,listening,done}", 64'({bus.busy, bus.listening, bus.done}),
            64'({m_e >= 0, m_e >= FIRE_LEN, m_done}));
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.speakers[i] && !prev_spk[i]) begin
                rise_cnt[i]++;
                if (first_rise[i] < 0) first_rise[i] = m_e;
            end
        end
        prev_spk = bus.speakers;
        if (bus.done) n_done++;
        if (bus.busy) n_busy++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'(addr);
        bus.cfg_data = DELAY_W'(data);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_burst();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic check_pulses(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("%s_rises_ch%0d", tag, i), 64'(rise_cnt[i]), 64'(BC));
            chk($sformatf("%s_first_ch%0d", tag, i), 64'(first_rise[i]), 64'(m_dly[i] + 1));
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        prev_spk = '0;
        model_reset();
        clear_obs();
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;

        // Power-on reset values
        #5;
        chk("por_speakers", 64'(bus.speakers), 64'd0);
        chk("por_status", 64'({bus.busy, bus.listening, bus.done}), 64'd0);
        run(2);
        rst_n = 1'b1;
        run(3);

        // Reset asserted in the middle of FIRE clears outputs without a clock edge
        start_burst();
        run($urandom_range(800, 1500));
        rst_n = 1'b0;
        #1;
        chk("async_rst_speakers", 64'(bus.speakers), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        model_reset();
        prev_spk = '0;
        run(2);
        rst_n = 1'b1;
        run(2);

        // All delays zero: every channel rises together; a write to ch5 during FIRE is ignored
        clear_obs();
        start_burst();
        run(2000);
        cfg_write(5, 500);
        while (m_e >= 0 && m_e < FIRE_LEN + 50) tick();
        check_pulses("flat");
        pulse_abort();
        chk("flat_no_done", 64'(n_done), 64'd0);
        run(3);

        // Steering table, ignored out-of-range writes, then a write colliding with start
        cfg_write(0, 0);
        cfg_write(1, 100);
        cfg_write(36, 1023);
        for (int i = 3; i < 36; i++) begin
            if (i != 5) cfg_write(i, $urandom_range(0, MAXD));
        end
        cfg_write(40, $urandom_range(0, MAXD));
        cfg_write($urandom_range(37, 63), $urandom_range(0, MAXD));
        clear_obs();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 6'd2;
        bus.cfg_data = DELAY_W'(50);
        start_burst();
        bus.cfg_we = 1'b0;
        // Stray starts during LISTEN and writes while busy must change nothing
        while (m_e >= 0) begin
            bus.start    = (m_e > FIRE_LEN) && (m_e < BUSY_LEN - 4) && ($urandom_range(0, 99) < 2);
            bus.cfg_we   = (m_e > 10) && (m_e < BUSY_LEN - 4) && ($urandom_range(0, 99) < 1);
            bus.cfg_addr = 6'($urandom_range(0, NUM_CH - 1));
            bus.cfg_data = DELAY_W'($urandom_range(0, MAXD));
            tick();
        end
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        check_pulses("steer");
        chk("steer_first_ch0", 64'(first_rise[0]), 64'd1);
        chk("steer_first_ch1", 64'(first_rise[1]), 64'd101);
        chk("steer_first_ch2", 64'(first_rise[2]), 64'd51);
        chk("steer_first_ch5", 64'(first_rise[5]), 64'd1);
        chk("steer_first_ch36", 64'(first_rise[36]), 64'd1024);
        chk("steer_done_pulses", 64'(n_done), 64'd1);
        chk("steer_busy_cycles", 64'(n_busy), 64'(1023 + 4800 + 24000));
        run(5);

        // Abort 2000 cycles into FIRE; abort also beats start in IDLE
        clear_obs();
        start_burst();
        run(1999);
        pulse_abort();
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_speakers", 64'(bus.speakers), 64'd0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        run(4);
        chk("abort_no_done", 64'(n_done), 64'd0);

        // A fresh burst after the abort runs normally with the same table
        clear_obs();
        start_burst();
        while (m_e >= 0 && m_e < FIRE_LEN + $urandom_range(10, 200)) tick();
        check_pulses("post_abort");
        pulse_abort();
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
